sram_mbist_ctrl: RTL and testbench

//  March C- built-in self-test engine that drives the single-port 64x64 sync SRAM (clk, we, addr, din, dout)

---
 rtl/sram_mbist_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sram_mbist_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mbist_ctrl.sv
// March C- built-in self-test engine for a single-port synchronous SRAM.
// Sequences M0..M5, checks read data one cycle after each read and records first-failure diagnostics.
module sram_mbist_ctrl #(
  parameter int unsigned   AW           = 6,
  parameter int unsigned   DW           = 64,
  parameter logic [DW-1:0] DATA_BG      = '0,
  parameter bit            STOP_ON_FAIL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [2:0]    fail_elem,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_xor,
  output logic [7:0]    err_cnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  localparam logic [AW-1:0] ADDR_MAX = '1;
  localparam logic [DW-1:0] BG_0     = DATA_BG;
  localparam logic [DW-1:0] BG_1     = ~DATA_BG;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_nxt, addr_step;
  logic          down, last;
  logic [2:0]    elem;
  logic [DW-1:0] rd_exp, wr_val;
  logic          rd_now, mismatch, stop;

  // Compare tag for the read issued in the previous cycle
  logic          cmp_vld;
  logic [DW-1:0] cmp_exp;
  logic [AW-1:0] cmp_addr;
  logic [2:0]    cmp_elem;

  logic          busy_nxt, done_nxt, pass_nxt, we_nxt, cmp_vld_nxt;
  logic [AW-1:0] mem_addr_nxt, fail_addr_nxt;
  logic [DW-1:0] mem_din_nxt, fail_xor_nxt;
  logic [2:0]    fail_elem_nxt;
  logic [7:0]    err_cnt_nxt;

  // Element number and expected read value of the current state
  always_comb begin
    elem   = 3'd0;
    rd_exp = BG_0;
    case (state)
      S_M1:    begin elem = 3'd1; rd_exp = BG_0; end
      S_M2:    begin elem = 3'd2; rd_exp = BG_1; end
      S_M3:    begin elem = 3'd3; rd_exp = BG_0; end
      S_M4:    begin elem = 3'd4; rd_exp = BG_1; end
      S_M5:    begin elem = 3'd5; rd_exp = BG_0; end
      default: ;
    endcase
  end

  assign rd_now   = (elem != 3'd0) && !mem_we;
  assign mismatch = cmp_vld && (mem_dout != cmp_exp);
  assign stop     = STOP_ON_FAIL && mismatch;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_elem <= '0;
      fail_addr <= '0;
      fail_xor  <= '0;
      err_cnt   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      cmp_vld   <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      cmp_elem  <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      fail_elem <= fail_elem_nxt;
      fail_addr <= fail_addr_nxt;
      fail_xor  <= fail_xor_nxt;
      err_cnt   <= err_cnt_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_din   <= mem_din_nxt;
      cmp_vld   <= cmp_vld_nxt;
      cmp_exp   <= rd_exp;
      cmp_addr  <= mem_addr;
      cmp_elem  <= elem;
    end
  end

  // Next state and next address; the address only jumps at element boundaries
  always_comb begin
    state_nxt = state;
    addr_nxt  = '0;
    down      = (state == S_M3) || (state == S_M4);
    last      = down ? (mem_addr == '0) : (mem_addr == ADDR_MAX);
    addr_step = down ? (mem_addr - AW'(1)) : (mem_addr + AW'(1));
    case (state)
      S_IDLE: if (start) state_nxt = S_M0;
      S_M0, S_M5: begin
        addr_nxt = addr_step;
        if (last) begin
          if (state == S_M0) state_nxt = S_M1;
          else               state_nxt = S_DRAIN;
        end
      end
      S_M1, S_M2, S_M3, S_M4: begin
        addr_nxt = mem_we ? addr_step : mem_addr;
        if (mem_we && last) begin
          case (state)
            S_M1:    state_nxt = S_M2;
            S_M2:    begin state_nxt = S_M3; addr_nxt = ADDR_MAX; end
            S_M3:    state_nxt = S_M4;
            default: begin state_nxt = S_M5; addr_nxt = '0; end
          endcase
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (stop) state_nxt = S_DONE;
  end

  // Next values of the registered outputs and result bookkeeping
  always_comb begin
    we_nxt        = 1'b0;
    wr_val        = BG_0;
    busy_nxt      = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
    done_nxt      = (state_nxt == S_DONE);
    pass_nxt      = pass;
    fail_elem_nxt = fail_elem;
    fail_addr_nxt = fail_addr;
    fail_xor_nxt  = fail_xor;
    err_cnt_nxt   = err_cnt;
    case (state_nxt)
      S_M0:                   we_nxt = 1'b1;
      S_M1, S_M2, S_M3, S_M4: we_nxt = (state_nxt == state) && !mem_we;
      default:                ;
    endcase
    if ((state_nxt == S_M1) || (state_nxt == S_M3)) wr_val = BG_1;
    mem_din_nxt  = we_nxt ? wr_val : '0;
    mem_addr_nxt = (busy_nxt && (state_nxt != S_DRAIN)) ? addr_nxt : '0;
    cmp_vld_nxt  = rd_now && !stop;

    if ((state == S_IDLE) && start) begin
      pass_nxt      = 1'b0;
      fail_elem_nxt = '0;
      fail_addr_nxt = '0;
      fail_xor_nxt  = '0;
      err_cnt_nxt   = '0;
    end else if (mismatch) begin
      if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
      if (err_cnt == 8'd0) begin
        fail_elem_nxt = cmp_elem;
        fail_addr_nxt = cmp_addr;
        fail_xor_nxt  = mem_dout ^ cmp_exp;
      end
    end
    if (state_nxt == S_DONE) pass_nxt = (err_cnt_nxt == 8'd0);
  end

endmodule

// File: tb/tb_sram_mbist_ctrl.sv
// Bench for sram_mbist_ctrl: cycle-by-cycle SRAM bus scoreboard plus end-of-run
// result checks against behavioural SRAMs with injectable faults.
`timescale 1ns/1ps
module tb_sram_mbist_ctrl;

  localparam int unsigned   AW      = 6;
  localparam int unsigned   DW      = 64;
  localparam int            DEPTH   = 64;
  localparam int            RUN_CYC = 642;
  localparam logic [DW-1:0] BG      = '0;
  localparam logic [DW-1:0] BI      = ~BG;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          we;
    logic          acc;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } exp_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start   = 1'b0;
  logic start_s = 1'b0;
  int   fault_mode = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  logic          busy, done, pass, mem_we;
  logic [2:0]    fail_elem;
  logic [AW-1:0] fail_addr, mem_addr;
  logic [DW-1:0] fail_xor, mem_din, dout_a;
  logic [7:0]    err_cnt;

  logic          busy_s, done_s, pass_s, mem_we_s;
  logic [2:0]    fail_elem_s;
  logic [AW-1:0] fail_addr_s, mem_addr_s;
  logic [DW-1:0] fail_xor_s, mem_din_s, dout_b;
  logic [7:0]    err_cnt_s;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  always #5 clk = ~clk;

  sram_mbist_ctrl #(.AW(AW), .DW(DW), .DATA_BG(BG), .STOP_ON_FAIL(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_xor(fail_xor), .err_cnt(err_cnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(dout_a)
  );

  sram_mbist_ctrl #(.AW(AW), .DW(DW), .DATA_BG(BG), .STOP_ON_FAIL(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .fail_elem(fail_elem_s), .fail_addr(fail_addr_s), .fail_xor(fail_xor_s), .err_cnt(err_cnt_s),
    .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_din(mem_din_s), .mem_dout(dout_b)
  );

  // Fault 1: bit 5 of addr 17 stuck at 0.  Fault 2: a write to addr 40 also lands in addr 41.
  function automatic logic [DW-1:0] stored(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return (fault_mode == 1 && a == AW'(17)) ? (d & ~64'h20) : d;
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem_a[mem_addr] <= stored(mem_addr, mem_din);
      if (fault_mode == 2 && mem_addr == AW'(40)) mem_a[41] <= mem_din;
    end else begin
      dout_a <= mem_a[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (mem_we_s) begin
      mem_b[mem_addr_s] <= stored(mem_addr_s, mem_din_s);
      if (fault_mode == 2 && mem_addr_s == AW'(40)) mem_b[41] <= mem_din_s;
    end else begin
      dout_b <= mem_b[mem_addr_s];
    end
  end

  function automatic exp_t mk(input logic b, input logic d, input logic w, input logic acc,
                              input int a, input logic [DW-1:0] din);
    exp_t e;
    e.busy = b;
    e.done = d;
    e.we   = w;
    e.acc  = acc;
    e.addr = AW'(a);
    e.din  = din;
    return e;
  endfunction

  // Expected bus activity of one full March C- run, cycles 1..642
  task automatic push_run();
    int a;
    for (int i = 0; i < DEPTH; i++) sb_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, i, BG));
    for (int e = 1; e <= 4; e++) begin
      for (int i = 0; i < DEPTH; i++) begin
        a = (e >= 3) ? (DEPTH - 1 - i) : i;
        sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, a, '0));
        sb_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, a, (e % 2 == 1) ? BI : BG));
      end
    end
    for (int i = 0; i < DEPTH; i++) sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, i, '0));
    sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 0, '0));
    sb_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, '0));
  endtask

  // Pulse (or hold) start on the main DUT and queue the expected bus traffic
  task automatic kick(input bit hold, input int n_runs);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < n_runs; r++) begin
      if (r > 0) sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, '0));
      push_run();
    end
    if (!hold) start = 1'b0;
  endtask

  // Scoreboard: one expected bus entry consumed per cycle
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      if (busy !== mon_e.busy || done !== mon_e.done || mem_we !== mon_e.we ||
          mem_din !== mon_e.din || (mon_e.acc && mem_addr !== mon_e.addr)) begin
        n_err++;
        $display("FAIL bus_seq (left=%0d) got busy=%b done=%b we=%b addr=%0d din=%h exp busy=%b done=%b we=%b addr=%0d din=%h",
                 sb_q.size(), busy, done, mem_we, mem_addr, mem_din,
                 mon_e.busy, mon_e.done, mon_e.we, mon_e.addr, mon_e.din);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, pass, fail_elem, fail_addr, fail_xor, err_cnt, mem_we, mem_addr, mem_din} !== '0) begin
      n_err++;
      $display("FAIL reset_main got %h exp 0",
               {busy, done, pass, fail_elem, fail_addr, fail_xor, err_cnt, mem_we, mem_addr, mem_din});
    end
    n_vec++;
    if ({busy_s, done_s, pass_s, fail_elem_s, fail_addr_s, fail_xor_s, err_cnt_s, mem_we_s, mem_addr_s, mem_din_s} !== '0) begin
      n_err++;
      $display("FAIL reset_stop got %h exp 0",
               {busy_s, done_s, pass_s, fail_elem_s, fail_addr_s, fail_xor_s, err_cnt_s, mem_we_s, mem_addr_s, mem_din_s});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, mem_we} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_no_start got busy/done/we=%b exp 000", {busy, done, mem_we});
    end
  endtask

  task automatic test_clean();
    fault_mode = 0;
    kick(1'b0, 1);
    repeat (RUN_CYC) @(negedge clk);
    n_vec++;
    if ({done, pass, err_cnt, fail_elem, fail_addr, fail_xor} !== {1'b1, 1'b1, 8'd0, 3'd0, 6'd0, 64'd0}) begin
      n_err++;
      $display("FAIL clean_result got done=%b pass=%b err=%0d elem=%0d addr=%0d xor=%h exp 1 1 0 0 0 0",
               done, pass, err_cnt, fail_elem, fail_addr, fail_xor);
    end
    @(negedge clk);
    n_vec++;
    if ({busy, done, pass} !== 3'b001) begin
      n_err++;
      $display("FAIL clean_hold got busy/done/pass=%b exp 001", {busy, done, pass});
    end
  endtask

  task automatic test_stuck_at();
    fault_mode = 1;
    kick(1'b0, 1);
    @(negedge clk);
    n_vec++;
    if ({pass, err_cnt} !== 9'd0) begin
      n_err++;
      $display("FAIL start_clears got pass=%b err=%0d exp 0 0", pass, err_cnt);
    end
    repeat (RUN_CYC - 1) @(negedge clk);
    n_vec++;
    if ({done, pass, err_cnt, fail_elem, fail_addr, fail_xor} !== {1'b1, 1'b0, 8'd2, 3'd2, 6'd17, 64'h20}) begin
      n_err++;
      $display("FAIL stuck_result got done=%b pass=%b err=%0d elem=%0d addr=%0d xor=%h exp 1 0 2 2 17 20",
               done, pass, err_cnt, fail_elem, fail_addr, fail_xor);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, pass, err_cnt, fail_elem, fail_addr, fail_xor} !== {1'b0, 1'b0, 8'd2, 3'd2, 6'd17, 64'h20}) begin
      n_err++;
      $display("FAIL stuck_hold got busy=%b pass=%b err=%0d elem=%0d addr=%0d xor=%h exp 0 0 2 2 17 20",
               busy, pass, err_cnt, fail_elem, fail_addr, fail_xor);
    end
  endtask

  task automatic test_stop_on_fail();
    fault_mode = 1;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    for (int k = 1; k <= 232; k++) begin
      @(negedge clk);
      n_vec++;
      if (busy_s !== (k < 229) || done_s !== (k == 229)) begin
        n_err++;
        $display("FAIL stop_timing cyc=%0d got busy=%b done=%b exp busy=%b done=%b",
                 k, busy_s, done_s, (k < 229), (k == 229));
      end
      if (k == 228) begin
        n_vec++;
        if ({mem_we_s, mem_addr_s, mem_din_s, err_cnt_s} !== {1'b1, 6'd17, BG, 8'd0}) begin
          n_err++;
          $display("FAIL stop_last_write got we=%b addr=%0d din=%h err=%0d exp 1 17 %h 0",
                   mem_we_s, mem_addr_s, mem_din_s, err_cnt_s, BG);
        end
      end
      if (k == 229) begin
        n_vec++;
        if ({mem_we_s, pass_s, err_cnt_s, fail_elem_s, fail_addr_s, fail_xor_s} !==
            {1'b0, 1'b0, 8'd1, 3'd2, 6'd17, 64'h20}) begin
          n_err++;
          $display("FAIL stop_result got we=%b pass=%b err=%0d elem=%0d addr=%0d xor=%h exp 0 0 1 2 17 20",
                   mem_we_s, pass_s, err_cnt_s, fail_elem_s, fail_addr_s, fail_xor_s);
        end
      end
    end
  endtask

  task automatic test_coupling();
    fault_mode = 2;
    kick(1'b0, 1);
    repeat (RUN_CYC) @(negedge clk);
    n_vec++;
    if ({done, pass, err_cnt, fail_elem, fail_addr, fail_xor} !== {1'b1, 1'b0, 8'd2, 3'd1, 6'd41, {DW{1'b1}}}) begin
      n_err++;
      $display("FAIL coupling_result got done=%b pass=%b err=%0d elem=%0d addr=%0d xor=%h exp 1 0 2 1 41 all-ones",
               done, pass, err_cnt, fail_elem, fail_addr, fail_xor);
    end
  endtask

  task automatic test_reset_mid_run();
    fault_mode = 0;
    kick(1'b0, 1);
    repeat (299) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_busy got busy=%b exp 1", busy);
    end
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    n_vec++;
    if ({busy, mem_we, done} !== 3'b000) begin
      n_err++;
      $display("FAIL async_abort got busy/we/done=%b exp 000", {busy, mem_we, done});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, pass, err_cnt} !== 11'd0) begin
      n_err++;
      $display("FAIL no_resume got busy=%b done=%b pass=%b err=%0d exp 0 0 0 0", busy, done, pass, err_cnt);
    end
    kick(1'b0, 1);
    repeat (RUN_CYC) @(negedge clk);
    n_vec++;
    if ({done, pass, err_cnt} !== {1'b1, 1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL restart_result got done=%b pass=%b err=%0d exp 1 1 0", done, pass, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    fault_mode = 0;
    kick(1'b1, 2);
    repeat (1000) @(negedge clk);
    start = 1'b0;
    repeat (2 * RUN_CYC + 1 - 1000) @(negedge clk);
    n_vec++;
    if ({done, pass, err_cnt} !== {1'b1, 1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL b2b_second_done got done=%b pass=%b err=%0d exp 1 1 0", done, pass, err_cnt);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_no_third got busy/done=%b exp 00", {busy, done});
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck_at();
    test_stop_on_fail();
    test_coupling();
    test_reset_mid_run();
    test_back_to_back();
    repeat (4) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d pending entries exp 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
